// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register with skid buffer, flush and optional stats (PIPE_STAGE_STATS_EN)
module pipe_stage_reg #(
  parameter int CTRL_W     = 8,
  parameter int DATA_W     = 128,
  parameter bit CLEAR_DATA = 1'b1,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              deliver;

  // Handshake flags decode straight from the state register, so neither
  // in_ready nor out_valid sees any combinational input path.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  // A beat offered during flush is dropped, so it never counts as accepted.
  assign accept  = in_valid && in_ready && !flush;
  assign deliver = out_valid && out_ready;

  // Occupancy FSM: main feeds the outputs, skid catches the beat accepted while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      if (CLEAR_DATA) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (accept) begin
            state     <= FULL;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end else if (deliver) begin
            // Bubble: control goes to zero, data is left as it was.
            state     <= EMPTY;
            main_ctrl <= '0;
          end
        end
        FULL: begin
          if (deliver) begin
            state     <= ONE;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
          end
        end
        default: begin
          state     <= EMPTY;
          main_ctrl <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  localparam logic [STAT_W-1:0] STAT_INC = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [STAT_W-1:0] stall_q;
  logic [STAT_W-1:0] flush_q;

  // Saturating event counters: stalled-output cycles and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_q))
        stall_q <= stall_q + STAT_INC;
      if (flush && !(&flush_q))
        flush_q <= flush_q + STAT_INC;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 16;

`ifdef PIPE_STAGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          a_in_ready, a_out_valid;
  logic [CW-1:0] a_out_ctrl;
  logic [DW-1:0] a_out_data;
  logic [15:0]   a_stall, a_flush;

  logic          b_in_ready, b_out_valid;
  logic [CW-1:0] b_out_ctrl;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_stall, b_flush;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0), .STAT_W(2)) dut_keep (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t q[$];
  logic [DW-1:0] held_a, held_b;
  int st_a, fl_a, st_b, fl_b;
  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    held_a = '0; held_b = '0;
    st_a = 0; fl_a = 0; st_b = 0; fl_b = 0;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_clock();
    bit acc, del;
    beat_t bt;
    acc = in_valid && (q.size() < 2) && !flush;
    del = (q.size() > 0) && out_ready;
    if ((q.size() > 0) && !out_ready) begin
      if (st_a < 65535) st_a++;
      if (st_b < 3) st_b++;
    end
    if (flush) begin
      if (fl_a < 65535) fl_a++;
      if (fl_b < 3) fl_b++;
      q.delete();
      held_a = '0;
    end else begin
      if (del) void'(q.pop_front());
      if (acc) begin
        bt.c = in_ctrl; bt.d = in_data;
        q.push_back(bt);
      end
      if (q.size() > 0) begin
        held_a = q[0].d;
        held_b = q[0].d;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [CW-1:0] ec;
    ec = (q.size() > 0) ? q[0].c : '0;
    chk({tag, ".in_ready"},  {31'd0, a_in_ready},  {31'd0, q.size() < 2});
    chk({tag, ".out_valid"}, {31'd0, a_out_valid}, {31'd0, q.size() > 0});
    chk({tag, ".out_ctrl"},  {24'd0, a_out_ctrl},  {24'd0, ec});
    chk({tag, ".out_data"},  {16'd0, a_out_data},  {16'd0, held_a});
    chk({tag, ".stall_cnt"}, {16'd0, a_stall},     STATS ? st_a : 0);
    chk({tag, ".flush_cnt"}, {16'd0, a_flush},     STATS ? fl_a : 0);
    chk({tag, ".k.in_ready"},  {31'd0, b_in_ready},  {31'd0, q.size() < 2});
    chk({tag, ".k.out_valid"}, {31'd0, b_out_valid}, {31'd0, q.size() > 0});
    chk({tag, ".k.out_ctrl"},  {24'd0, b_out_ctrl},  {24'd0, ec});
    chk({tag, ".k.out_data"},  {16'd0, b_out_data},  {16'd0, held_b});
    chk({tag, ".k.stall_cnt"}, {30'd0, b_stall},     STATS ? st_b : 0);
    chk({tag, ".k.flush_cnt"}, {30'd0, b_flush},     STATS ? fl_b : 0);
  endtask

  task automatic step(input string tag, input logic v, input logic [DW-1:0] d,
                      input logic r, input logic f);
    in_valid  = v;
    in_ctrl   = CW'($urandom_range(1, 255));
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    model_clock();
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: 0..7 back to back.
    for (int i = 0; i < 8; i++) begin
      step("stream", 1'b1, DW'(i), 1'b1, 1'b0);
      chk("stream.data_seq", {16'd0, a_out_data}, i);
    end
    step("drain", 1'b0, 16'h0, 1'b1, 1'b0);

    // Backpressure: A then B with downstream stalled.
    step("bp.a", 1'b1, 16'hA0A0, 1'b0, 1'b0);
    step("bp.b", 1'b1, 16'hB0B0, 1'b0, 1'b0);
    chk("bp.full_in_ready", {31'd0, a_in_ready}, 32'd0);
    chk("bp.head_is_a", {16'd0, a_out_data}, 32'hA0A0);
    step("bp.hold", 1'b1, 16'hC0C0, 1'b0, 1'b0);
    step("bp.rel_a", 1'b0, 16'h0, 1'b1, 1'b0);
    chk("bp.b_next", {16'd0, a_out_data}, 32'hB0B0);
    chk("bp.ready_back", {31'd0, a_in_ready}, 32'd1);
    step("bp.rel_b", 1'b0, 16'h0, 1'b1, 1'b0);

    // Flush while FULL with a beat offered.
    step("fl.a", 1'b1, 16'h1111, 1'b0, 1'b0);
    step("fl.b", 1'b1, 16'h2222, 1'b0, 1'b0);
    step("fl.go", 1'b1, 16'h3333, 1'b0, 1'b1);
    chk("fl.clear_data", {16'd0, a_out_data}, 32'h0);
    chk("fl.keep_data", {16'd0, b_out_data}, 32'h1111);
    chk("fl.valid", {31'd0, a_out_valid}, 32'd0);
    chk("fl.count", {16'd0, a_flush}, STATS ? 32'd1 : 32'd0);
    step("fl.after", 1'b0, 16'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges while FULL.
    step("ar.a", 1'b1, 16'h4444, 1'b0, 1'b0);
    step("ar.b", 1'b1, 16'h5555, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("ar.async");
    @(negedge clk);
    rst_n = 1'b1;
    step("ar.first", 1'b1, 16'h6666, 1'b0, 1'b0);
    chk("ar.latency", {16'd0, a_out_data}, 32'h6666);

    // Saturation on the 2-bit counter: six stalled cycles.
    for (int i = 0; i < 6; i++) step("sat", 1'b0, 16'h0, 1'b0, 1'b0);
    chk("sat.stall2", {30'd0, b_stall}, STATS ? 32'd3 : 32'd0);
    step("sat.drain", 1'b0, 16'h0, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), DW'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
